// File: rtl/id_decode_stage_if.sv
// ID -> ID/EX bundle: the decoded control word, the register operands, the immediate,
// the destination addresses and PC+4 of the instruction currently in decode.
// The decode stage drives it through the master modport. The ID/EX register reads it
// through the slave modport.
interface id_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic [2:0]      iALUOp;
  logic            iRegDest;
  logic            iRegWrite;
  logic            iALUSrc;
  logic            iMemRead;
  logic            iMemWrite;
  logic            iMemToReg;
  logic            iBranch;
  logic [XLEN-1:0] ioperand1;
  logic [XLEN-1:0] ioperand2;
  logic [XLEN-1:0] iextinst;
  logic [RA_W-1:0] iregdest1;
  logic [RA_W-1:0] iregdest2;
  logic [XLEN-1:0] iNextInst;

  modport master (
    output iALUOp, iRegDest, iRegWrite, iALUSrc, iMemRead, iMemWrite, iMemToReg, iBranch,
    output ioperand1, ioperand2, iextinst, iregdest1, iregdest2, iNextInst
  );

  modport slave (
    input iALUOp, iRegDest, iRegWrite, iALUSrc, iMemRead, iMemWrite, iMemToReg, iBranch,
    input ioperand1, ioperand2, iextinst, iregdest1, iregdest2, iNextInst
  );
endinterface

// File: rtl/id_decode_stage.sv
// Instruction-decode stage. It contains the IF/ID register, a 32x32 register file with
// 2 read ports and 1 write port, the control decoder, the sign extender and the
// load-use hazard detector.
// Optional feature: when ID_WB_BYPASS_EN is defined, a register read that hits the
// register being written back in the same cycle returns wb_data (write-through).
// When it is not defined, the read returns the stored value, and the new value becomes
// visible on the following cycle.
module id_decode_stage #(
  parameter int              XLEN     = 32,
  parameter int              RA_W     = 5,
  parameter logic [XLEN-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              res,
  input  logic [XLEN-1:0]   if_inst,
  input  logic [XLEN-1:0]   if_next_pc,
  input  logic              flush,
  input  logic              ex_memread,
  input  logic [RA_W-1:0]   ex_rt,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  id_decode_stage_if.master idex
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;

  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] regs [2**RA_W];
  logic [5:0]      opcode;
  logic [RA_W-1:0] rs;
  logic [RA_W-1:0] rt;
  logic            uses_rt;
  ctrl_t           ctrl;

  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];

  // IF/ID register: a flush has priority over a stall and loads a bubble.
  // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      inst <= NOP_INST;
      pc   <= '0;
    end else if (flush) begin
      inst <= NOP_INST;
      pc   <= '0;
    end else if (!stall) begin
      inst <= if_inst;
      pc   <= if_next_pc;
    end
  end

  // Register file write port. Writes to R0 are dropped.
  // NOTE: this array is cleared on reset on purpose (architectural zero state), so it maps
  // to flops and not to a RAM macro.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] read_reg(input logic [RA_W-1:0] addr);
    if (addr == '0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr == addr) return wb_data;
`endif
    return regs[addr];
  endfunction

  // Combinational read ports for rs and rt.
  always_comb begin
    idex.ioperand1 = read_reg(rs);
    idex.ioperand2 = read_reg(rt);
  end

  // Load-use hazard. rt counts as a source only for R-type, sw and beq.
  // A flush or a reset cancels the stall.
  always_comb begin
    uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    stall   = res && !flush && ex_memread && (ex_rt != '0) &&
              ((ex_rt == rs) || ((ex_rt == rt) && uses_rt));
  end

  // Control decoder. Unknown opcodes, the NOP encoding and stalled cycles all become a
  // bubble with every control at zero.
  // NOTE: every field gets a default first, so no latch can be inferred on any path.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: if (inst != NOP_INST) begin
                  ctrl.reg_dest  = 1'b1;
                  ctrl.reg_write = 1'b1;
                  ctrl.alu_op    = 3'b010;
                end
      OP_LW:    begin
                  ctrl.alu_src    = 1'b1;
                  ctrl.mem_read   = 1'b1;
                  ctrl.mem_to_reg = 1'b1;
                  ctrl.reg_write  = 1'b1;
                end
      OP_SW:    begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.mem_write = 1'b1;
                end
      OP_BEQ:   begin
                  ctrl.branch = 1'b1;
                  ctrl.alu_op = 3'b001;
                end
      OP_ADDI:  begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.reg_write = 1'b1;
                end
      OP_ANDI:  begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.reg_write = 1'b1;
                  ctrl.alu_op    = 3'b011;
                end
      OP_ORI:   begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.reg_write = 1'b1;
                  ctrl.alu_op    = 3'b100;
                end
      OP_SLTI:  begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.reg_write = 1'b1;
                  ctrl.alu_op    = 3'b101;
                end
      default:  ctrl = '0;
    endcase
    if (stall) ctrl = '0;
  end

  assign idex.iRegDest  = ctrl.reg_dest;
  assign idex.iRegWrite = ctrl.reg_write;
  assign idex.iALUSrc   = ctrl.alu_src;
  assign idex.iMemRead  = ctrl.mem_read;
  assign idex.iMemWrite = ctrl.mem_write;
  assign idex.iMemToReg = ctrl.mem_to_reg;
  assign idex.iBranch   = ctrl.branch;
  assign idex.iALUOp    = ctrl.alu_op;
  assign idex.iextinst  = {{(XLEN-16){inst[15]}}, inst[15:0]};
  assign idex.iregdest1 = rt;
  assign idex.iregdest2 = inst[15:11];
  assign idex.iNextInst = pc;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed testbench for id_decode_stage. All expected values are hand-computed constants.
// The control word is compared as the 10-bit vector
// {RegDest, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Branch, ALUOp[2:0]}.
module tb_id_decode_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [9:0] C_NONE = 10'b0000000_000;
  localparam logic [9:0] C_R    = 10'b1100000_010;
  localparam logic [9:0] C_LW   = 10'b0111010_000;
  localparam logic [9:0] C_SW   = 10'b0010100_000;
  localparam logic [9:0] C_BEQ  = 10'b0000001_001;
  localparam logic [9:0] C_ADDI = 10'b0110000_000;
  localparam logic [9:0] C_ANDI = 10'b0110000_011;
  localparam logic [9:0] C_ORI  = 10'b0110000_100;
  localparam logic [9:0] C_SLTI = 10'b0110000_101;

  logic            clk = 1'b0;
  logic            res;
  logic [XLEN-1:0] if_inst, if_next_pc, wb_data;
  logic            flush, ex_memread, wb_we;
  logic [RA_W-1:0] ex_rt, wb_addr;
  logic            stall;
  int              n_tests = 0;
  int              n_fail  = 0;

  id_decode_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) idex ();

  id_decode_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .res(res), .if_inst(if_inst), .if_next_pc(if_next_pc), .flush(flush),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .idex(idex)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ctl();
    return {idex.iRegDest, idex.iRegWrite, idex.iALUSrc, idex.iMemRead, idex.iMemWrite,
            idex.iMemToReg, idex.iBranch, idex.iALUOp};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then sample away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    if_inst    = inst;
    if_next_pc = pc;
    tick();
  endtask

  initial begin
    res = 1'b0; flush = 1'b0; ex_memread = 1'b1; ex_rt = 5'd5;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    if_inst = 32'h00A53020; if_next_pc = 32'h0000_0100;

    // Reset held while the clock toggles.
    repeat (3) tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ctl", {22'd0, ctl()}, {22'd0, C_NONE});
    check("rst_op1", idex.ioperand1, 32'd0);
    check("rst_ext", idex.iextinst, 32'd0);
    check("rst_pc", idex.iNextInst, 32'd0);
    check("rst_rd", {22'd0, idex.iregdest1, idex.iregdest2}, 32'd0);

    // Write R5 and load add r6,r5,r5 on the first edge after reset release.
    @(negedge clk);
    res = 1'b1; ex_memread = 1'b0; ex_rt = '0;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678;
    if_next_pc = 32'h0000_0104;
    tick();
    wb_we = 1'b0;
    check("add_pc", idex.iNextInst, 32'h0000_0104);
    check("add_op1", idex.ioperand1, 32'h12345678);
    check("add_op2", idex.ioperand2, 32'h12345678);
    check("add_ctl", {22'd0, ctl()}, {22'd0, C_R});
    check("add_rd2", {27'd0, idex.iregdest2}, 32'd6);
    check("add_ext", idex.iextinst, 32'h0000_3020);

    // lw r2,-4(r1)
    load(32'h8C22FFFC, 32'h0000_0108);
    check("lw_ctl", {22'd0, ctl()}, {22'd0, C_LW});
    check("lw_ext", idex.iextinst, 32'hFFFF_FFFC);
    check("lw_rd1", {27'd0, idex.iregdest1}, 32'd2);

    // Load-use hazard: add r3,r2,r1 with a load to r2 in EX.
    load(32'h00411820, 32'h0000_010C);
    ex_memread = 1'b1; ex_rt = 5'd2; #1;
    check("lu_rs_stall", {31'd0, stall}, 32'd1);
    check("lu_rs_ctl", {22'd0, ctl()}, {22'd0, C_NONE});
    check("lu_rs_rd2", {27'd0, idex.iregdest2}, 32'd3);
    load(32'h2000_0000, 32'h0000_0110);
    check("lu_hold_pc", idex.iNextInst, 32'h0000_010C);
    ex_memread = 1'b0; #1;
    check("lu_release", {21'd0, stall, ctl()}, {21'd0, 1'b0, C_R});
    ex_memread = 1'b1; ex_rt = 5'd0; #1;
    check("lu_r0", {31'd0, stall}, 32'd0);
    ex_rt = 5'd1; #1;
    check("lu_rt_rtype", {31'd0, stall}, 32'd1);

    // sw r1,4(r2): rt is a source, so the hazard applies.
    ex_memread = 1'b0;
    load(32'hAC410004, 32'h0000_0114);
    check("sw_ctl", {22'd0, ctl()}, {22'd0, C_SW});
    ex_memread = 1'b1; ex_rt = 5'd1; #1;
    check("sw_stall", {21'd0, stall, ctl()}, {21'd0, 1'b1, C_NONE});

    // addi r1,r2,5: rt is only a destination, so there is no hazard.
    ex_memread = 1'b0;
    load(32'h20410005, 32'h0000_0118);
    ex_memread = 1'b1; ex_rt = 5'd1; #1;
    check("addi_nostall", {21'd0, stall, ctl()}, {21'd0, 1'b0, C_ADDI});
    ex_memread = 1'b0;

    // Remaining opcodes, and an unknown opcode that decodes to a bubble.
    load(32'h30410007, 32'h0000_011C);
    check("andi_ctl", {22'd0, ctl()}, {22'd0, C_ANDI});
    load(32'h34410007, 32'h0000_0120);
    check("ori_ctl", {22'd0, ctl()}, {22'd0, C_ORI});
    load(32'h28418000, 32'h0000_0124);
    check("slti_ctl", {22'd0, ctl()}, {22'd0, C_SLTI});
    check("slti_ext", idex.iextinst, 32'hFFFF_8000);
    load(32'h10410003, 32'h0000_0128);
    check("beq_ctl", {22'd0, ctl()}, {22'd0, C_BEQ});
    load(32'h0800_0000, 32'h0000_012C);
    check("j_bubble", {22'd0, ctl()}, {22'd0, C_NONE});

    // A flush arriving together with a stall: the flush wins and IF/ID becomes NOP.
    load(32'h00411820, 32'h0000_0130);
    ex_memread = 1'b1; ex_rt = 5'd2; #1;
    check("fl_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; #1;
    check("fl_stall_off", {31'd0, stall}, 32'd0);
    if_inst = 32'h00A53020; if_next_pc = 32'h0000_0134;
    tick();
    flush = 1'b0; ex_memread = 1'b0;
    check("fl_pc", idex.iNextInst, 32'd0);
    check("fl_ctl", {22'd0, ctl()}, {22'd0, C_NONE});

    // Write-back versus a read in the same cycle.
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_1111;
    load(32'h20870001, 32'h0000_0138);
    check("wb_old", idex.ioperand1, 32'h1111_1111);
    wb_data = 32'hDEADBEEF; #1;
`ifdef ID_WB_BYPASS_EN
    check("wb_same_cycle", idex.ioperand1, 32'hDEADBEEF);
`else
    check("wb_same_cycle", idex.ioperand1, 32'h1111_1111);
`endif
    tick();
    wb_we = 1'b0;
    check("wb_next_cycle", idex.ioperand1, 32'hDEADBEEF);

    // A write-back to R0 is dropped, and R0 always reads as zero.
    load(32'h20070001, 32'h0000_013C);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; #1;
    check("r0_same", idex.ioperand1, 32'd0);
    tick();
    wb_we = 1'b0;
    check("r0_next", idex.ioperand1, 32'd0);

    // Reset asserted during a stall: the stall drops at once and IF/ID holds NOP.
    load(32'h00411820, 32'h0000_0140);
    ex_memread = 1'b1; ex_rt = 5'd2; #1;
    check("rs_pre_stall", {31'd0, stall}, 32'd1);
    res = 1'b0; #1;
    check("rs_stall_off", {31'd0, stall}, 32'd0);
    check("rs_op1_clr", idex.ioperand1, 32'd0);
    @(negedge clk);
    res = 1'b1; #1;
    check("rs_nop_pc", idex.iNextInst, 32'd0);
    check("rs_nop_ctl", {21'd0, stall, ctl()}, {21'd0, 1'b0, C_NONE});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
